data_mem_responder: RTL and testbench

- Data-memory responder: the far end of the core datapath's load/store port.
- Accepts one load or store per valid/ready handshake and performs byte, half or word access against an internal word array.
- Returns read data (sign- or zero-extended) or a write acknowledgement after a programmable latency, so the core can be exercised against non-zero-wait-state memory.

---
 rtl/mem_pkg.sv | 19 +
 rtl/mem_lane_align.sv | 41 ++++
 rtl/data_mem_responder.sv | 156 +++++++++++++++
 tb/tb_data_mem_responder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the data-memory responder: access sizes, FSM states and counter width.
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10,
        MEM_RSVD = 2'b11
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering shared by loads and stores: byte enables, store merge and load extension.
module mem_lane_align
    import mem_pkg::*;
(
    input  mem_size_t   i_size,
    input  logic [1:0]  i_offset,
    input  logic        i_unsigned,
    input  logic [31:0] i_stored,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_merged,
    output logic [31:0] o_load
);

    logic [31:0] w_lanes;
    logic [31:0] w_shifted;

    always_comb begin
        w_shifted = i_stored >> {i_offset, 3'b000};
        o_be      = 4'b1111;
        w_lanes   = i_wdata;
        o_load    = i_stored;
        case (i_size)
            MEM_BYTE: begin
                o_be    = 4'b0001 << i_offset;
                w_lanes = {4{i_wdata[7:0]}};
                o_load  = {{24{~i_unsigned & w_shifted[7]}}, w_shifted[7:0]};
            end
            MEM_HALF: begin
                o_be    = i_offset[1] ? 4'b1100 : 4'b0011;
                w_lanes = {2{i_wdata[15:0]}};
                o_load  = {{16{~i_unsigned & w_shifted[15]}}, w_shifted[15:0]};
            end
            default: ;
        endcase
        for (int unsigned i = 0; i < 4; i++) begin
            o_merged[8*i +: 8] = o_be[i] ? w_lanes[8*i +: 8] : i_stored[8*i +: 8];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder with programmable response latency over an internal word array.
// Define DMEM_ERR_EN to fault misaligned, reserved-size and out-of-range accesses.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned IDXW = $clog2(DEPTH_WORDS);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_write;
    logic             r_unsigned;
    logic [1:0]       r_size;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_rdata;
    logic             r_err;
    logic [31:0]      r_mem [DEPTH_WORDS];

    logic             w_accept;
    logic             w_commit;
    logic             w_write;
    logic             w_unsigned;
    logic             w_err;
    logic [1:0]       w_size_raw;
    mem_size_t        w_size;
    logic [1:0]       w_off;
    logic [31:0]      w_addr;
    logic [31:0]      w_wdata;
    logic [IDXW-1:0]  w_idx;
    logic [3:0]       w_be;
    logic [31:0]      w_merged;
    logic [31:0]      w_load;

    assign w_accept = (r_state == IDLE) && req_valid;
    // With single-cycle latency the commit edge is the accept edge, so the live request feeds the access path
    assign w_commit = (LATENCY == 1) ? w_accept : ((r_state == WAIT) && (r_cnt == '0));

    assign w_write    = (r_state == IDLE) ? req_write    : r_write;
    assign w_unsigned = (r_state == IDLE) ? req_unsigned : r_unsigned;
    assign w_size_raw = (r_state == IDLE) ? req_size     : r_size;
    assign w_addr     = (r_state == IDLE) ? req_addr     : r_addr;
    assign w_wdata    = (r_state == IDLE) ? req_wdata    : r_wdata;
    assign w_idx      = w_addr[IDXW+1:2];

`ifdef DMEM_ERR_EN
    always_comb begin
        w_size = mem_size_t'(w_size_raw);
        w_off  = w_addr[1:0];
        w_err  = (w_size == MEM_RSVD)
              || ((w_size == MEM_HALF) && w_addr[0])
              || ((w_size == MEM_WORD) && (w_addr[1:0] != 2'b00))
              || ((w_addr >> (IDXW + 2)) != 32'd0);
    end
`else
    logic w_unused;
    assign w_unused = ^w_addr[31:IDXW+2];

    always_comb begin
        w_size = (w_size_raw == 2'b11) ? MEM_WORD : mem_size_t'(w_size_raw);
        w_err  = 1'b0;
        w_off  = w_addr[1:0];
        case (w_size)
            MEM_HALF: w_off = {w_addr[1], 1'b0};
            MEM_WORD: w_off = 2'b00;
            default:  ;
        endcase
    end
`endif

    mem_lane_align u_align (
        .i_size     (w_size),
        .i_offset   (w_off),
        .i_unsigned (w_unsigned),
        .i_stored   (r_mem[w_idx]),
        .i_wdata    (w_wdata),
        .o_be       (w_be),
        .o_merged   (w_merged),
        .o_load     (w_load)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_write    <= 1'b0;
            r_unsigned <= 1'b0;
            r_size     <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_write    <= req_write;
                r_unsigned <= req_unsigned;
                r_size     <= req_size;
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
                r_cnt      <= CNT_W'(LATENCY - 1);
            end else if ((r_state == WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_commit) begin
                r_rdata <= (w_write || w_err) ? '0 : w_load;
                r_err   <= w_err;
            end
        end
    end

    // Array is not reset; the reset gate keeps an aborted store from landing
    always_ff @(posedge clk) begin
        if (w_commit && w_write && !w_err && !reset) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_merged[8*i +: 8];
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_next = (LATENCY == 1) ? RESP : WAIT;
            WAIT:    if (r_cnt == '0) w_next = RESP;
            RESP:    if (resp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (r_state == IDLE) && !reset;
        resp_valid = (r_state == RESP);
        resp_rdata = r_rdata;
        resp_err   = r_err;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized plus directed bench for data_mem_responder against a byte-level memory model.
module tb_data_mem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int          n_pass  = 0;
    int          n_fail  = 0;
    int          n_total = 0;
    logic [31:0] mm [DEPTH];
    logic [31:0] last_rd;
    logic        last_err;

    always #5 clk = ~clk;

    data_mem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Little-endian byte-array view of the memory; stores update it, loads read and extend
    function automatic void model(input logic wr, input logic [1:0] sz, input logic uns,
                                  input logic [31:0] addr, input logic [31:0] wd,
                                  output logic [31:0] rd, output logic er);
        int unsigned nb, a, b;
        logic [31:0] v;
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        er = 1'b0;
        rd = '0;
        v  = '0;
`ifdef DMEM_ERR_EN
        if (sz == 2'd3 || (addr % nb) != 0 || addr >= DEPTH * 4) er = 1'b1;
        a = addr;
`else
        a = addr % (DEPTH * 4);
        a = a - (a % nb);
`endif
        if (er) return;
        for (int unsigned i = 0; i < nb; i++) begin
            b = a + i;
            if (wr) mm[b / 4][8 * (b % 4) +: 8] = wd[8 * i +: 8];
            else    v[8 * i +: 8] = mm[b / 4][8 * (b % 4) +: 8];
        end
        if (!wr) begin
            if (nb < 4 && !uns && v[8 * nb - 1]) v = v | (32'hFFFF_FFFF << (8 * nb));
            rd = v;
        end
    endfunction

    task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, input int hold);
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [31:0] rd0;
        int          lat;
        model(wr, sz, uns, addr, wd, exp_rd, exp_err);
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
        req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        lat = 0;
        while (!resp_valid && lat <= 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(LAT));
        if (!resp_valid) return;
        rd0 = resp_rdata;
        last_rd = resp_rdata;
        last_err = resp_err;
        chk("rdata", resp_rdata, exp_rd);
        chk("err", {31'd0, resp_err}, {31'd0, exp_err});
        resp_ready = 1'b0;
        repeat (hold) begin
            @(posedge clk); #1;
            chk("hold_valid", {31'd0, resp_valid}, 32'd1);
            chk("hold_rdata", resp_rdata, rd0);
            chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        #1;
        chk("handoff_req_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("post_valid", {31'd0, resp_valid}, 32'd0);
        chk("post_req_ready", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        logic        wr, uns;
        logic [1:0]  sz;
        logic [31:0] addr;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", {31'd0, resp_err}, 32'd0);
        reset = 1'b0;
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);

        for (int unsigned k = 0; k < 64; k++) issue(1'b1, 2'd2, 1'b0, 32'(k * 4), $urandom, 0);

        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 0);
        chk("sw_err", {31'd0, last_err}, 32'd0);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);
        chk("lw_deadbeef", last_rd, 32'hDEAD_BEEF);

        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h0, 0);
        issue(1'b1, 2'd0, 1'b0, 32'h13, 32'h80, 0);
        issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0);
        chk("lb_0x13", last_rd, 32'hFFFF_FF80);
        issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0);
        chk("lbu_0x13", last_rd, 32'h0000_0080);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);
        chk("lw_after_sb", last_rd, 32'h8000_0000);

        issue(1'b1, 2'd1, 1'b0, 32'h22, 32'h8001, 0);
        issue(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 0);
        chk("lh_0x22", last_rd, 32'hFFFF_8001);
        issue(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 5);
        chk("lhu_0x22", last_rd, 32'h0000_8001);

        issue(1'b0, 2'd2, 1'b0, 32'h12, 32'h0, 0);
`ifdef DMEM_ERR_EN
        chk("lw_misaligned_err", {31'd0, last_err}, 32'd1);
        chk("lw_misaligned_rdata", last_rd, 32'd0);
`endif
        issue(1'b1, 2'd2, 1'b0, 32'h1000, 32'hA5A5_5A5A, 0);
        issue(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 0);

        issue(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 0);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h40; req_wdata = 32'h1234;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("midrst_valid", {31'd0, resp_valid}, 32'd0);
        chk("midrst_rdata", resp_rdata, 32'd0);
        chk("midrst_err", {31'd0, resp_err}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        issue(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 0);

        for (int k = 0; k < 150; k++) begin
            wr   = 1'($urandom_range(0, 1));
            sz   = 2'($urandom_range(0, 3));
            uns  = 1'($urandom_range(0, 1));
            addr = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) addr = addr + 32'h1000 * 32'($urandom_range(1, 3));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) addr[0] = 1'b0;
                if (sz == 2'd2) addr[1:0] = 2'b00;
            end
            issue(wr, sz, uns, addr, $urandom, int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
